// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_ex_stage
// Purpose  : ID/EX pipeline register for a MIPS-style five-stage pipeline.
//            Captures decode control, operands, immediate, return address and
//            register specifiers. Detects load-use hazards against the
//            instruction currently in EX and inserts a single bubble. Flush
//            squashes the incoming instruction, and Hold freezes the stage.
// Ports    : Clk, Rst_n (synchronous, active low)
//            Ctrl_ID[20:0], ReadData1_ID, ReadData2_ID, Imm_ID, PCPlus4_ID,
//            Rs_ID, Rt_ID, Rd_ID, Valid_ID, Flush, Hold        (inputs)
//            Ctrl_EX[20:0], ReadData1_EX, ReadData2_EX, Imm_EX, PCPlus4_EX,
//            Rs_EX, Rt_EX, Rd_EX, Valid_EX                     (registered)
//            LoadUseStall (combinational), BubbleCount[15:0]
// Options  : ID_EX_PERF_EN -- when defined, BubbleCount is a saturating
//            count of bubbles loaded. When undefined it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module id_ex_stage (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic [20:0] Ctrl_ID,
  input  logic [31:0] ReadData1_ID,
  input  logic [31:0] ReadData2_ID,
  input  logic [31:0] Imm_ID,
  input  logic [31:0] PCPlus4_ID,
  input  logic [4:0]  Rs_ID,
  input  logic [4:0]  Rt_ID,
  input  logic [4:0]  Rd_ID,
  input  logic        Valid_ID,
  input  logic        Flush,
  input  logic        Hold,
  output logic [20:0] Ctrl_EX,
  output logic [31:0] ReadData1_EX,
  output logic [31:0] ReadData2_EX,
  output logic [31:0] Imm_EX,
  output logic [31:0] PCPlus4_EX,
  output logic [4:0]  Rs_EX,
  output logic [4:0]  Rt_EX,
  output logic [4:0]  Rd_EX,
  output logic        Valid_EX,
  output logic        LoadUseStall,
  output logic [15:0] BubbleCount
);

  // MemRead position inside the control bundle
  localparam int unsigned C_MEMREAD_BIT = 10;

  logic [20:0] ctrl_q, ctrl_d;
  logic [31:0] rd1_q, rd1_d;
  logic [31:0] rd2_q, rd2_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] pc4_q, pc4_d;
  logic [4:0]  rs_q, rs_d;
  logic [4:0]  rt_q, rt_d;
  logic [4:0]  rd_q, rd_d;
  logic        valid_q, valid_d;

  logic        w_load_use;
  logic        w_bubble;

  // A load in EX whose destination is read by the decoding instruction.
  // Destination $zero never carries a real value, so it never stalls.
  assign w_load_use = valid_q & ctrl_q[C_MEMREAD_BIT] & (rt_q != 5'd0) &
                      ((rt_q == Rs_ID) | (rt_q == Rt_ID)) & Valid_ID & ~Hold;

  always_comb begin
    ctrl_d   = ctrl_q;
    rd1_d    = rd1_q;
    rd2_d    = rd2_q;
    imm_d    = imm_q;
    pc4_d    = pc4_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    valid_d  = valid_q;
    w_bubble = 1'b0;

    // Flush outranks Hold so a squash is never lost while EX is busy.
    if (Flush) begin
      w_bubble = 1'b1;
    end else if (Hold) begin
      w_bubble = 1'b0;
    end else if (w_load_use) begin
      w_bubble = 1'b1;
    end else begin
      ctrl_d  = Valid_ID ? Ctrl_ID : 21'd0;
      rd1_d   = ReadData1_ID;
      rd2_d   = ReadData2_ID;
      imm_d   = Imm_ID;
      pc4_d   = PCPlus4_ID;
      rs_d    = Rs_ID;
      rt_d    = Rt_ID;
      rd_d    = Rd_ID;
      valid_d = Valid_ID;
    end

    // An all-zero bubble has no write, memory, branch or link side effect,
    // and Valid_EX = 0 means it cannot retrigger the load-use check.
    if (w_bubble) begin
      ctrl_d  = 21'd0;
      rd1_d   = 32'd0;
      rd2_d   = 32'd0;
      imm_d   = 32'd0;
      pc4_d   = 32'd0;
      rs_d    = 5'd0;
      rt_d    = 5'd0;
      rd_d    = 5'd0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      ctrl_q  <= 21'd0;
      rd1_q   <= 32'd0;
      rd2_q   <= 32'd0;
      imm_q   <= 32'd0;
      pc4_q   <= 32'd0;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      rd_q    <= 5'd0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      rd1_q   <= rd1_d;
      rd2_q   <= rd2_d;
      imm_q   <= imm_d;
      pc4_q   <= pc4_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      valid_q <= valid_d;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [15:0] bub_cnt_q, bub_cnt_d;

  always_comb begin
    bub_cnt_d = bub_cnt_q;
    if (w_bubble && (bub_cnt_q != 16'hFFFF)) begin
      bub_cnt_d = bub_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      bub_cnt_q <= 16'd0;
    end else begin
      bub_cnt_q <= bub_cnt_d;
    end
  end

  assign BubbleCount = bub_cnt_q;
`else
  assign BubbleCount = 16'h0000;
`endif

  assign Ctrl_EX      = ctrl_q;
  assign ReadData1_EX = rd1_q;
  assign ReadData2_EX = rd2_q;
  assign Imm_EX       = imm_q;
  assign PCPlus4_EX   = pc4_q;
  assign Rs_EX        = rs_q;
  assign Rt_EX        = rt_q;
  assign Rd_EX        = rd_q;
  assign Valid_EX     = valid_q;
  assign LoadUseStall = w_load_use;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_ex_stage
// Purpose  : Directed, table-driven self-checking bench for id_ex_stage.
//            Honours ID_EX_PERF_EN for the expected BubbleCount values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;

  localparam logic [20:0] C_LW   = 21'h000C05; // MemToReg, MemRead, RegWrite, ALUSrc=01
  localparam logic [20:0] C_ADDI = 21'h000015; // ALUOp=0010, RegWrite, ALUSrc=01
  localparam logic [20:0] C_ADD  = 21'h000094; // RegDst, ALUOp=0010, RegWrite
  localparam logic [20:0] C_JALC = 21'h180004; // jal, sel=10, RegWrite

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic [20:0] Ctrl_ID;
  logic [31:0] ReadData1_ID, ReadData2_ID, Imm_ID, PCPlus4_ID;
  logic [4:0]  Rs_ID, Rt_ID, Rd_ID;
  logic        Valid_ID, Flush, Hold;
  logic [20:0] Ctrl_EX;
  logic [31:0] ReadData1_EX, ReadData2_EX, Imm_EX, PCPlus4_EX;
  logic [4:0]  Rs_EX, Rt_EX, Rd_EX;
  logic        Valid_EX, LoadUseStall;
  logic [15:0] BubbleCount;

  id_ex_stage dut (
    .Clk(Clk), .Rst_n(Rst_n), .Ctrl_ID(Ctrl_ID),
    .ReadData1_ID(ReadData1_ID), .ReadData2_ID(ReadData2_ID),
    .Imm_ID(Imm_ID), .PCPlus4_ID(PCPlus4_ID),
    .Rs_ID(Rs_ID), .Rt_ID(Rt_ID), .Rd_ID(Rd_ID),
    .Valid_ID(Valid_ID), .Flush(Flush), .Hold(Hold),
    .Ctrl_EX(Ctrl_EX), .ReadData1_EX(ReadData1_EX), .ReadData2_EX(ReadData2_EX),
    .Imm_EX(Imm_EX), .PCPlus4_EX(PCPlus4_EX),
    .Rs_EX(Rs_EX), .Rt_EX(Rt_EX), .Rd_EX(Rd_EX),
    .Valid_EX(Valid_EX), .LoadUseStall(LoadUseStall), .BubbleCount(BubbleCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        rst_n, flush, hold, valid;
    logic [20:0] ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] a, b, imm, pc;
    logic        chk_stall, exp_stall;
    logic        exp_valid;
    logic [20:0] exp_ctrl;
    logic [4:0]  exp_rs, exp_rt, exp_rd;
    logic [31:0] exp_a, exp_b, exp_imm, exp_pc;
    logic        bub;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_bc = 16'd0;

  function automatic vec_t mk(
    input logic rn, fl, ho, va, input logic [20:0] c,
    input logic [4:0] s, t, d, input logic [31:0] a, b, im, p,
    input logic cs, es, ev, input logic [20:0] ec,
    input logic [4:0] xs, xt, xd, input logic [31:0] xa, xb, xi, xp,
    input logic bub);
    vec_t v;
    v.rst_n = rn; v.flush = fl; v.hold = ho; v.valid = va; v.ctrl = c;
    v.rs = s; v.rt = t; v.rd = d; v.a = a; v.b = b; v.imm = im; v.pc = p;
    v.chk_stall = cs; v.exp_stall = es; v.exp_valid = ev; v.exp_ctrl = ec;
    v.exp_rs = xs; v.exp_rt = xt; v.exp_rd = xd;
    v.exp_a = xa; v.exp_b = xb; v.exp_imm = xi; v.exp_pc = xp; v.bub = bub;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    Rst_n = v.rst_n; Flush = v.flush; Hold = v.hold; Valid_ID = v.valid;
    Ctrl_ID = v.ctrl; Rs_ID = v.rs; Rt_ID = v.rt; Rd_ID = v.rd;
    ReadData1_ID = v.a; ReadData2_ID = v.b; Imm_ID = v.imm; PCPlus4_ID = v.pc;
  endtask

  // Expected bubble counter: cleared by reset, +1 per bubble edge, saturating.
  task automatic model_bc(input logic rn, input logic bub);
`ifdef ID_EX_PERF_EN
    if (!rn) exp_bc = 16'd0;
    else if (bub && exp_bc != 16'hFFFF) exp_bc = exp_bc + 16'd1;
`else
    exp_bc = 16'd0;
`endif
  endtask

  task automatic check_outputs(input string tag, input vec_t v);
    check({tag, " valid"}, {127'd0, Valid_EX}, {127'd0, v.exp_valid});
    check({tag, " ctrl"}, {107'd0, Ctrl_EX}, {107'd0, v.exp_ctrl});
    check({tag, " spec"}, {113'd0, Rs_EX, Rt_EX, Rd_EX}, {113'd0, v.exp_rs, v.exp_rt, v.exp_rd});
    check({tag, " data"}, {ReadData1_EX, ReadData2_EX, Imm_EX, PCPlus4_EX},
          {v.exp_a, v.exp_b, v.exp_imm, v.exp_pc});
    check({tag, " bubblecount"}, {112'd0, BubbleCount}, {112'd0, exp_bc});
  endtask

  initial begin
    vec_t hv;
    string tag;
    Rst_n = 1'b0; Flush = 1'b0; Hold = 1'b0; Valid_ID = 1'b0; Ctrl_ID = '0;
    Rs_ID = '0; Rt_ID = '0; Rd_ID = '0;
    ReadData1_ID = '0; ReadData2_ID = '0; Imm_ID = '0; PCPlus4_ID = '0;

    //             rn fl ho va ctrl          rs rt rd  a            b            imm          pc            cs es  ev exp_ctrl  xs xt xd xa           xb           xi           xp           bub
    vecs.push_back(mk(0, 0, 0, 1, 21'h1FFFFF, 1, 2, 3, 32'hFFFFFFFF, 32'hEEEEEEEE, 32'hDDDDDDDD, 32'hCCCCCCCC, 0, 0, 0, 21'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(0, 0, 0, 1, C_ADD, 4, 5, 6, 32'h1, 32'h2, 32'h3, 32'h4, 1, 0, 0, 21'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 1, C_ADDI, 1, 2, 0, 32'h10, 32'h20, 32'h5, 32'h104, 1, 0, 1, C_ADDI, 1, 2, 0, 32'h10, 32'h20, 32'h5, 32'h104, 0));
    vecs.push_back(mk(1, 0, 0, 1, C_LW, 9, 8, 0, 32'h1000, 32'h0, 32'h4, 32'h108, 1, 0, 1, C_LW, 9, 8, 0, 32'h1000, 32'h0, 32'h4, 32'h108, 0));
    vecs.push_back(mk(1, 0, 0, 1, C_ADD, 8, 3, 4, 32'h11, 32'h22, 32'h0, 32'h10C, 1, 1, 0, 21'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 0, 0, 1, C_ADD, 8, 3, 4, 32'h11, 32'h22, 32'h0, 32'h10C, 1, 0, 1, C_ADD, 8, 3, 4, 32'h11, 32'h22, 32'h0, 32'h10C, 0));
    vecs.push_back(mk(1, 0, 0, 1, C_LW, 5, 0, 0, 32'h200, 32'h0, 32'h8, 32'h110, 1, 0, 1, C_LW, 5, 0, 0, 32'h200, 32'h0, 32'h8, 32'h110, 0));
    vecs.push_back(mk(1, 0, 0, 1, C_ADD, 0, 0, 6, 32'h0, 32'h0, 32'h0, 32'h114, 1, 0, 1, C_ADD, 0, 0, 6, 32'h0, 32'h0, 32'h0, 32'h114, 0));
    vecs.push_back(mk(1, 0, 0, 1, C_LW, 2, 7, 0, 32'h300, 32'h0, 32'hC, 32'h118, 1, 0, 1, C_LW, 2, 7, 0, 32'h300, 32'h0, 32'hC, 32'h118, 0));
    vecs.push_back(mk(1, 0, 1, 1, C_ADD, 1, 7, 9, 32'h1, 32'h2, 32'h3, 32'h11C, 1, 0, 1, C_LW, 2, 7, 0, 32'h300, 32'h0, 32'hC, 32'h118, 0));
    vecs.push_back(mk(1, 0, 1, 1, C_ADDI, 7, 4, 0, 32'h5, 32'h6, 32'h7, 32'h120, 1, 0, 1, C_LW, 2, 7, 0, 32'h300, 32'h0, 32'hC, 32'h118, 0));
    vecs.push_back(mk(1, 1, 1, 1, C_ADDI, 7, 4, 0, 32'h5, 32'h6, 32'h7, 32'h120, 1, 0, 0, 21'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 1, 0, 1, C_JALC, 1, 2, 31, 32'h7, 32'h8, 32'h9, 32'h124, 1, 0, 0, 21'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 0, 0, 0, C_ADD, 3, 4, 5, 32'h33, 32'h44, 32'h55, 32'h128, 1, 0, 0, 21'h0, 3, 4, 5, 32'h33, 32'h44, 32'h55, 32'h128, 0));
    vecs.push_back(mk(1, 0, 0, 1, C_LW, 6, 9, 0, 32'h400, 32'h0, 32'h10, 32'h12C, 1, 0, 1, C_LW, 6, 9, 0, 32'h400, 32'h0, 32'h10, 32'h12C, 0));
    vecs.push_back(mk(1, 0, 0, 0, C_ADD, 1, 9, 2, 32'h1, 32'h2, 32'h3, 32'h130, 1, 0, 0, 21'h0, 1, 9, 2, 32'h1, 32'h2, 32'h3, 32'h130, 0));
    vecs.push_back(mk(1, 0, 0, 1, C_LW, 6, 9, 0, 32'h400, 32'h0, 32'h10, 32'h134, 1, 0, 1, C_LW, 6, 9, 0, 32'h400, 32'h0, 32'h10, 32'h134, 0));
    vecs.push_back(mk(1, 0, 0, 1, C_ADD, 2, 9, 3, 32'h5, 32'h6, 32'h0, 32'h138, 1, 1, 0, 21'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 1));
    vecs.push_back(mk(1, 0, 0, 1, C_ADD, 2, 9, 3, 32'h5, 32'h6, 32'h0, 32'h138, 1, 0, 1, C_ADD, 2, 9, 3, 32'h5, 32'h6, 32'h0, 32'h138, 0));
    vecs.push_back(mk(1, 0, 0, 1, C_LW, 0, 5, 0, 32'h500, 32'h0, 32'h14, 32'h13C, 1, 0, 1, C_LW, 0, 5, 0, 32'h500, 32'h0, 32'h14, 32'h13C, 0));
    vecs.push_back(mk(0, 0, 0, 1, C_ADD, 5, 1, 2, 32'h7, 32'h8, 32'h0, 32'h140, 1, 1, 0, 21'h0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 0));
    vecs.push_back(mk(1, 0, 0, 1, C_ADD, 5, 1, 2, 32'h7, 32'h8, 32'h0, 32'h140, 1, 0, 1, C_ADD, 5, 1, 2, 32'h7, 32'h8, 32'h0, 32'h140, 0));

    // Table: drive on negedge, check stall mid-cycle, check EX after the edge.
    foreach (vecs[i]) begin
      @(negedge Clk);
      drive(vecs[i]);
      #1;
      tag = $sformatf("vec%0d", i);
      if (vecs[i].chk_stall)
        check({tag, " stall"}, {127'd0, LoadUseStall}, {127'd0, vecs[i].exp_stall});
      @(posedge Clk);
      model_bc(vecs[i].rst_n, vecs[i].bub);
      #1;
      check_outputs(tag, vecs[i]);
    end

    // Hold for three cycles with changing ID inputs: EX stays put.
    hv = mk(1, 0, 0, 1, C_ADDI, 3, 4, 0, 32'hA, 32'hB, 32'h5, 32'h200, 0, 0, 1, C_ADDI, 3, 4, 0, 32'hA, 32'hB, 32'h5, 32'h200, 0);
    @(negedge Clk);
    drive(hv);
    @(posedge Clk);
    model_bc(1'b1, 1'b0);
    #1;
    check_outputs("addi load", hv);
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      Hold = 1'b1; Ctrl_ID = C_JALC; Rs_ID = 5'(k + 10); Imm_ID = 32'(k + 99);
      ReadData1_ID = 32'hDEAD0000 + 32'(k); PCPlus4_ID = 32'h300 + 32'(k);
      @(posedge Clk);
      #1;
      check_outputs($sformatf("hold%0d", k), hv);
    end

    // Continuous Flush: counter saturates (or stays zero without the option).
    @(negedge Clk);
    Hold = 1'b0; Flush = 1'b1;
`ifdef ID_EX_PERF_EN
    for (int k = 0; k < 65540; k++) begin
      @(posedge Clk);
      model_bc(1'b1, 1'b1);
    end
    #1;
    check("saturation", {112'd0, BubbleCount}, {112'd0, 16'hFFFF});
    check("saturation model", {112'd0, exp_bc}, {112'd0, 16'hFFFF});
`else
    for (int k = 0; k < 20; k++) begin
      @(posedge Clk);
      #1;
      check($sformatf("no counter %0d", k), {112'd0, BubbleCount}, 128'd0);
    end
`endif
    check("flush valid", {127'd0, Valid_EX}, 128'd0);
    check("flush ctrl", {107'd0, Ctrl_EX}, 128'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have port Clk, input, 1, rising-edge clock for all state.
REQ-002 SHALL have port Rst_n, input, 1, synchronous active-low reset sampled on rising Clk.
REQ-003 SHALL have port Ctrl_ID, input, 21, decode control bundle {jal, sel[1:0], BitSel[1:0], BranchLogicOp[2:0], ZeroExtend, MemToReg, MemRead, MemWrite, Branch, RegDst, ALUOp[3:0], RegWrite, ALUSrc[1:0]} (MSB..LSB).
REQ-004 SHALL have ports ReadData1_ID, ReadData2_ID, Imm_ID, PCPlus4_ID, input, 32 each, operands, extended immediate and return address.
REQ-005 SHALL have ports Rs_ID, Rt_ID, Rd_ID, input, 5 each, register specifiers.
REQ-006 SHALL have port Valid_ID, input, 1, decode slot holds a real instruction.
REQ-007 SHALL have port Flush, input, 1, squash the instruction entering EX (taken branch/jump).
REQ-008 SHALL have port Hold, input, 1, EX busy; keep all EX registers unchanged.
REQ-009 SHALL have outputs Ctrl_EX (21), ReadData1_EX, ReadData2_EX, Imm_EX, PCPlus4_EX (32), Rs_EX, Rt_EX, Rd_EX (5), Valid_EX (1): registered copies.
REQ-010 SHALL have output LoadUseStall, 1, combinational request to freeze PC and IF/ID.
REQ-011 SHALL have output BubbleCount, 16, bubbles inserted (see Configuration).

Function
REQ-012 SHALL update registers only on rising Clk; data latency ID->EX exactly one cycle.
REQ-013 SHALL drive LoadUseStall = Valid_EX & MemRead_EX & (Rt_EX != 0) & ((Rt_EX == Rs_ID) | (Rt_EX == Rt_ID)) & Valid_ID & ~Hold.
REQ-014 SHALL apply per-edge priority: reset > Flush > Hold > LoadUseStall > normal load.
REQ-015 SHALL, on Flush, load a bubble: Ctrl_EX = 0, Valid_EX = 0, all data/specifier outputs = 0.
REQ-016 SHALL, on Hold (no Flush), keep every EX register and BubbleCount unchanged.
REQ-017 SHALL, on LoadUseStall (no Flush, no Hold), load a bubble identical to REQ-015.
REQ-018 SHALL otherwise load all *_ID inputs into *_EX; Valid_EX = Valid_ID; Ctrl_EX = Ctrl_ID when Valid_ID else 0.
REQ-019 SHALL guarantee a bubble has RegWrite, MemWrite, MemRead, Branch, jal = 0 and sel = 00, so it has no architectural effect.
REQ-020 SHALL insert exactly one bubble per load-use hazard: after the bubble Valid_EX = 0, so LoadUseStall deasserts next cycle.
REQ-021 SHALL treat Rt_EX = 0 as no hazard (writes to $zero ignored).

Reset
REQ-022 SHALL, with Rst_n = 0 at a rising edge, clear all outputs to 0 (Valid_EX = 0, Ctrl_EX = 0, BubbleCount = 0), overriding Flush/Hold.
REQ-023 SHALL, with reset asserted, hold LoadUseStall at 0 because Valid_EX is 0.
REQ-024 SHALL discard an instruction in flight when reset asserts mid-stall; no stall persists after reset release.

Configuration
REQ-025 SHALL, with macro ID_EX_PERF_EN defined, increment BubbleCount on each edge that loads a bubble via REQ-015 or REQ-017, saturating at 16'hFFFF; Hold edges do not count.
REQ-026 SHALL, without ID_EX_PERF_EN, tie BubbleCount to 16'h0000 and implement no counter logic.

Verification
REQ-027 Reset: Rst_n=0 with Valid_ID=1, Ctrl_ID=21'h1FFFFF -> after edge Ctrl_EX=0, Valid_EX=0, BubbleCount=0.
REQ-028 Pass-through: addi (RegWrite=1, ALUSrc=01, Imm_ID=32'h5), Valid_ID=1 -> next edge Ctrl_EX=Ctrl_ID, Imm_EX=32'h5, Valid_EX=1.
REQ-029 Load-use: lw $8 in EX (MemRead=1, Rt_EX=8), add with Rs_ID=8 -> LoadUseStall=1; next edge Valid_EX=0; LoadUseStall=0; BubbleCount=1 with ID_EX_PERF_EN.
REQ-030 Zero reg: lw $0 in EX, Rs_ID=0 -> LoadUseStall=0, instruction loads normally.
REQ-031 Hold vs Flush: Hold=1 three cycles -> EX outputs constant; Hold=1 and Flush=1 same edge -> bubble loaded, BubbleCount +1.
REQ-032 Saturation (ID_EX_PERF_EN): Flush=1 for 65540 cycles -> BubbleCount = 16'hFFFF; without macro BubbleCount = 0 throughout.
